spi_deserializer: RTL and testbench

- SPI receive end: samples sclk/mosi driven by the SPI serializer, assembles DATAWIDTH-bit words MSB first, and pushes each word into a downstream FIFO through a write_en/write_data/full interface.
- sclk is slower than clk, so sclk and mosi are oversampled in the clk domain through a synchronizer and an edge detector.
- An idle timeout ends a partial frame; the partial word is discarded and reported.

---
 rtl/spi_deserializer.sv | 164 ++++++++++++++++
 tb/tb_spi_deserializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : spi_deserializer
// Description : SPI receive end. Oversamples sclk/mosi in the clk domain,
//               assembles DATAWIDTH-bit words MSB first and pushes each
//               completed word into a downstream FIFO. An idle timeout
//               aborts a partially received word.
// Ports       : clk        - system clock
//               rst        - asynchronous active-high reset
//               sclk       - serial clock from the serializer (idles low)
//               mosi       - serial data, valid at sclk rising edge
//               full       - downstream FIFO full
//               write_en   - single-cycle FIFO write strobe
//               write_data - assembled word, valid while write_en is high
//               busy       - a word is partially received
//               overflow   - sticky: a completed word was dropped (full)
//               frame_err  - single-cycle pulse: partial word timed out
// Revision    : 1.0 - initial release
// ============================================================================
module spi_deserializer #(
    parameter int DATAWIDTH       = 32,
    parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH),
    parameter int SYNC_STAGES     = 2,
    parameter int IDLE_TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 full,
    output logic                 write_en,
    output logic [DATAWIDTH-1:0] write_data,
    output logic                 busy,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int c_TIMEOUT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [BITCOUNTERWIDTH:0] c_CNT_ONE  = (BITCOUNTERWIDTH+1)'(1);
    localparam logic [BITCOUNTERWIDTH:0] c_CNT_LAST = (BITCOUNTERWIDTH+1)'(DATAWIDTH-1);
    localparam logic [c_TIMEOUT_W-1:0]   c_TIMEOUT_LAST = c_TIMEOUT_W'(IDLE_TIMEOUT-1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RECV  = 2'd1;
    localparam logic [1:0] c_S_WRITE = 2'd2;

    logic [SYNC_STAGES-1:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0]   r_mosi_sync;
    logic                     r_sclk_q;
    logic                     w_sclk_s;
    logic                     w_mosi_s;
    logic                     w_rise;

    logic [1:0]               r_state;
    logic [DATAWIDTH-1:0]     r_shift;
    logic [DATAWIDTH-1:0]     w_shift_next;
    logic [BITCOUNTERWIDTH:0] r_bitcnt;
    logic [c_TIMEOUT_W-1:0]   r_timeout;

    // sclk and mosi pass through identical chains so the sampled data bit
    // is aligned with the detected clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_q    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_q    <= w_sclk_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_q;

    // Shift-left so the first received bit ends up in the MSB.
    generate
        if (DATAWIDTH > 1) begin : g_shift_wide
            assign w_shift_next = {r_shift[DATAWIDTH-2:0], w_mosi_s};
        end else begin : g_shift_one
            assign w_shift_next = w_mosi_s;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_timeout  <= '0;
            write_en   <= 1'b0;
            write_data <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            write_en  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    busy <= 1'b0;
                    if (w_rise) begin
                        r_shift   <= w_shift_next;
                        r_bitcnt  <= c_CNT_ONE;
                        r_timeout <= '0;
                        if (DATAWIDTH == 1) begin
                            r_state <= c_S_WRITE;
                        end else begin
                            r_state <= c_S_RECV;
                            busy    <= 1'b1;
                        end
                    end
                end

                c_S_RECV: begin
                    if (w_rise) begin
                        r_shift   <= w_shift_next;
                        r_bitcnt  <= r_bitcnt + c_CNT_ONE;
                        r_timeout <= '0;
                        // Count before this sample was DATAWIDTH-1, so this
                        // bit completes the word.
                        if (r_bitcnt == c_CNT_LAST) begin
                            r_state <= c_S_WRITE;
                            busy    <= 1'b0;
                        end
                    end else if (r_timeout == c_TIMEOUT_LAST) begin
                        frame_err <= 1'b1;
                        r_bitcnt  <= '0;
                        r_timeout <= '0;
                        r_state   <= c_S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        r_timeout <= r_timeout + c_TIMEOUT_W'(1);
                    end
                end

                c_S_WRITE: begin
                    if (!full) begin
                        write_en   <= 1'b1;
                        write_data <= r_shift;
                    end else begin
                        overflow <= 1'b1;
                    end
                    r_bitcnt  <= '0;
                    r_timeout <= '0;
                    r_state   <= c_S_IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    r_bitcnt  <= '0;
                    r_timeout <= '0;
                    r_state   <= c_S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_deserializer
// Description : Self-checking bench for spi_deserializer. A vector table of
//               back-to-back words (with per-word full control) plus directed
//               sequences for reset mid-word and idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_deserializer;

    localparam int DW   = 32;
    localparam int SYNC = 2;
    localparam int TO   = 16;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          full = 1'b0;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          overflow;
    logic          frame_err;

    spi_deserializer #(
        .DATAWIDTH   (DW),
        .SYNC_STAGES (SYNC),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .full      (full),
        .write_en  (write_en),
        .write_data(write_data),
        .busy      (busy),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int end_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log: every write pulse and frame error, with latency measured
    // from the pin-level rising edge of the last bit sent.
    logic [DW-1:0] wq_data[$];
    int            wq_lat[$];
    logic          wq_ovf[$];
    int            fq_lat[$];

    always @(negedge clk) begin
        if (write_en) begin
            wq_data.push_back(write_data);
            wq_lat.push_back(cyc - end_cyc);
            wq_ovf.push_back(overflow);
        end
        if (frame_err) fq_lat.push_back(cyc - end_cyc);
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          full;
        logic          exp_we;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected one", name);
    endtask

    // One sclk period = 4 clk: low 2 clk (mosi changes), high 2 clk.
    task automatic send_bit(input logic b, input bit last);
        @(posedge clk); #1; sclk = 1'b0; mosi = b;
        @(posedge clk); #1;
        @(posedge clk); #1; sclk = 1'b1; if (last) end_cyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic f);
        for (int i = DW-1; i >= 0; i--) begin
            if (i == 0) full = f;
            send_bit(d[i], i == 0);
        end
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1; sclk = 1'b0; mosi = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wq_data.delete(); wq_lat.delete(); wq_ovf.delete(); fq_lat.delete();
    endtask

    initial begin
        int k;
        vecs[0] = '{32'hA5C3_0F81, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0001, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h1234_5678, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h9ABC_DEF0, 1'b0, 1'b1, 1'b1};

        // ---------------- reset state
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_write_en",   32'(write_en),  32'd0);
        chk("rst_write_data", write_data,     32'd0);
        chk("rst_busy",       32'(busy),      32'd0);
        chk("rst_overflow",   32'(overflow),  32'd0);
        chk("rst_frame_err",  32'(frame_err), 32'd0);

        // ---------------- reset mid-word
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        sclk = 1'b0; mosi = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        #1;
        chk("midrst_write_en",   32'(write_en),  32'd0);
        chk("midrst_write_data", write_data,     32'd0);
        chk("midrst_busy",       32'(busy),      32'd0);
        chk("midrst_overflow",   32'(overflow),  32'd0);
        chk("midrst_frame_err",  32'(frame_err), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        send_word(32'h0000_00FF, 1'b0);
        go_idle(12);
        chk("ff_writes", 32'(wq_data.size()), 32'd1);
        if (wq_data.size() > 0) begin
            chk("ff_data", wq_data[0], 32'h0000_00FF);
            chk("ff_lat",  32'(wq_lat[0]), 32'(SYNC + 2));
        end else begin
            miss("ff_data");
        end
        chk("ff_frame_errs", 32'(fq_lat.size()), 32'd0);
        clear_logs();

        // ---------------- table: back-to-back words with full control
        for (int v = 0; v < 5; v++) send_word(vecs[v].data, vecs[v].full);
        go_idle(12);
        k = 0;
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].exp_we) begin
                if (k < wq_data.size()) begin
                    chk($sformatf("vec%0d_data", v), wq_data[k], vecs[v].data);
                    chk($sformatf("vec%0d_lat",  v), 32'(wq_lat[k]), 32'(SYNC + 2));
                    chk($sformatf("vec%0d_ovf",  v), 32'(wq_ovf[k]), 32'(vecs[v].exp_ovf));
                end else begin
                    miss($sformatf("vec%0d_write", v));
                end
                k++;
            end
        end
        chk("tbl_writes",     32'(wq_data.size()), 32'(k));
        chk("tbl_frame_errs", 32'(fq_lat.size()),  32'd0);
        chk("tbl_overflow",   32'(overflow),       32'd1);
        chk("tbl_busy",       32'(busy),           32'd0);
        clear_logs();

        // ---------------- idle timeout on a 7-bit partial word
        for (int i = 0; i < 7; i++) send_bit(1'b1, i == 6);
        chk("to_busy_before", 32'(busy), 32'd1);
        go_idle(TO + 10);
        chk("to_frame_errs", 32'(fq_lat.size()), 32'd1);
        if (fq_lat.size() > 0) chk("to_lat", 32'(fq_lat[0]), 32'(SYNC + TO + 1));
        else miss("to_lat");
        chk("to_writes",      32'(wq_data.size()), 32'd0);
        chk("to_busy_after",  32'(busy),           32'd0);
        clear_logs();

        send_word(32'hDEAD_BEEF, 1'b0);
        go_idle(12);
        chk("db_writes", 32'(wq_data.size()), 32'd1);
        if (wq_data.size() > 0) begin
            chk("db_data", wq_data[0], 32'hDEAD_BEEF);
            chk("db_lat",  32'(wq_lat[0]), 32'(SYNC + 2));
        end else begin
            miss("db_data");
        end
        chk("db_frame_errs", 32'(fq_lat.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
